// File: rtl/mem_swap_ctrl_pkg.sv
// Shared definitions for the swap controller: FSM state encoding and default geometry.
package mem_swap_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_RD_B = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_B = 3'd4
    } state_t;

endpackage

// File: rtl/mem_swap_ctrl_mem_2r_1w.sv
// Two-read / one-write register-file memory; reads are combinational, the write is on posedge.
module mem_2r_1w
    import mem_swap_ctrl_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int depth = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             wr,
    input  logic [depth-1:0] wr_addr,
    input  logic [width-1:0] wr_data,
    input  logic [depth-1:0] rd_addr0,
    output logic [width-1:0] rd_data0,
    input  logic [depth-1:0] rd_addr1,
    output logic [width-1:0] rd_data1
);

    // Contents are not reset here; the controller clears them with its INIT sweep.
    logic [width-1:0] mem_r [2**depth];

    // Single write port
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data0 = mem_r[rd_addr0];
    assign rd_data1 = mem_r[rd_addr1];

endmodule

// File: rtl/mem_swap_ctrl.sv
// Sequences clear, load and atomic two-entry swap traffic onto the single write port of mem_2r_1w.
module mem_swap_ctrl
    import mem_swap_ctrl_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int depth = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [depth-1:0] ld_addr,
    input  logic [width-1:0] ld_data,
    output logic             ld_ready,
    input  logic             swap_req,
    input  logic [depth-1:0] swap_addr_a,
    input  logic [depth-1:0] swap_addr_b,
    output logic             swap_ready,
    output logic             swap_done,
    input  logic [depth-1:0] rd_addr,
    output logic [width-1:0] rd_data,
    output logic             rd_valid
);

    // Counter is one bit wider than the address so the sweep ends on a terminal count, never a wrap.
    localparam logic [depth:0] init_last = {1'b0, {depth{1'b1}}};
    localparam logic [depth:0] cnt_one   = {{depth{1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nx;
    logic [depth:0]   init_cnt_r;
    logic [depth-1:0] addr_a_r;
    logic [depth-1:0] addr_b_r;
    logic [width-1:0] data_a_r;
    logic [width-1:0] data_b_r;
    logic             swap_done_r;

    logic             ld_ready_s;
    logic             swap_ready_s;
    logic             swap_acc_s;
    logic             wr_s;
    logic [depth-1:0] wr_addr_s;
    logic [width-1:0] wr_data_s;
    logic [depth-1:0] rd_addr0_s;
    logic [width-1:0] rd_data0_s;
    logic             mem_wr_s;

    // Next-state, handshake and write-port mux
    always_comb begin
        state_nx     = state_r;
        ld_ready_s   = 1'b0;
        swap_ready_s = 1'b0;
        swap_acc_s   = 1'b0;
        wr_s         = 1'b0;
        wr_addr_s    = '0;
        wr_data_s    = '0;
        rd_addr0_s   = swap_addr_a;
        case (state_r)
            ST_INIT: begin
                wr_s      = 1'b1;
                wr_addr_s = init_cnt_r[depth-1:0];
                if (init_cnt_r == init_last) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_INIT;
                end
            end
            ST_IDLE: begin
                ld_ready_s   = 1'b1;
                swap_ready_s = !ld_valid;
                if (ld_valid) begin
                    wr_s      = 1'b1;
                    wr_addr_s = ld_addr;
                    wr_data_s = ld_data;
                    state_nx  = ST_IDLE;
                end else if (swap_req) begin
                    swap_acc_s = 1'b1;
                    state_nx   = ST_RD_B;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RD_B: begin
                rd_addr0_s = addr_b_r;
                state_nx   = ST_WR_A;
            end
            ST_WR_A: begin
                wr_s      = 1'b1;
                wr_addr_s = addr_a_r;
                wr_data_s = data_b_r;
                state_nx  = ST_WR_B;
            end
            ST_WR_B: begin
                wr_s      = 1'b1;
                wr_addr_s = addr_b_r;
                wr_data_s = data_a_r;
                state_nx  = ST_IDLE;
            end
            default: begin
                state_nx = ST_INIT;
            end
        endcase
    end

    // A swap interrupted by reset must not leave a partial write behind.
    assign mem_wr_s = wr_s & ~rst;

    // State register, init sweep counter and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= '0;
            swap_done_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            swap_done_r <= (state_r == ST_WR_B);
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + cnt_one;
            end else begin
                init_cnt_r <= init_cnt_r;
            end
        end
    end

    // Swap operand capture through read port 0
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_a_r <= '0;
            addr_b_r <= '0;
            data_a_r <= '0;
            data_b_r <= '0;
        end else if (swap_acc_s) begin
            addr_a_r <= swap_addr_a;
            addr_b_r <= swap_addr_b;
            data_a_r <= rd_data0_s;
        end else if (state_r == ST_RD_B) begin
            data_b_r <= rd_data0_s;
        end
    end

    mem_2r_1w #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clk      (clk),
        .wr       (mem_wr_s),
        .wr_addr  (wr_addr_s),
        .wr_data  (wr_data_s),
        .rd_addr0 (rd_addr0_s),
        .rd_data0 (rd_data0_s),
        .rd_addr1 (rd_addr),
        .rd_data1 (rd_data)
    );

    assign ld_ready   = ld_ready_s;
    assign swap_ready = swap_ready_s;
    assign swap_done  = swap_done_r;
    assign rd_valid   = (state_r != ST_INIT);

endmodule

// File: tb/tb_mem_swap_ctrl.sv
// Scoreboard bench for mem_swap_ctrl: stimulus queues expected lookups and done-pulse cycles, a monitor checks them.
module tb_mem_swap_ctrl;

    logic       clk;
    logic       rst;
    logic       ld_valid;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       swap_req;
    logic [3:0] swap_addr_a;
    logic [3:0] swap_addr_b;
    logic       swap_ready;
    logic       swap_done;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] rd_q [$];
    int         done_q [$];
    logic       rd_stb = 1'b0;

    mem_swap_ctrl #(.width(8), .depth(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .swap_req    (swap_req),
        .swap_addr_a (swap_addr_a),
        .swap_addr_b (swap_addr_b),
        .swap_ready  (swap_ready),
        .swap_done   (swap_done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares lookups and done pulses against the queues
    always @(negedge clk) begin
        if (rd_stb) begin
            if (rd_q.size() == 0) begin
                chk("rd_q_underflow", 32'd1, 32'd0);
            end else begin
                chk("rd_data", {24'd0, rd_data}, {24'd0, rd_q.pop_front()});
            end
        end
        if (swap_done !== 1'b0) begin
            if (done_q.size() == 0) begin
                chk("swap_done_unexpected", {31'd0, swap_done}, 32'd0);
            end else begin
                chk("swap_done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [3:0] a, input logic [7:0] e);
        rd_addr = a;
        rd_q.push_back(e);
        rd_stb = 1'b1;
        tick();
        rd_stb = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    // Issue in cycle t, check busy for t+1..t+3, return at the start of t+4
    task automatic swap(input logic [3:0] a, input logic [3:0] b);
        swap_req    = 1'b1;
        swap_addr_a = a;
        swap_addr_b = b;
        done_q.push_back(cyc + 4);
        tick();
        swap_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("swap_ready_busy", {31'd0, swap_ready}, 32'd0);
            tick();
        end
    endtask

    task automatic init_sweep();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("init_ld_ready", {31'd0, ld_ready}, 32'd0);
            chk("init_rd_valid", {31'd0, rd_valid}, 32'd0);
            tick();
        end
        @(negedge clk);
        chk("ready_after_init", {31'd0, ld_ready}, 32'd1);
        chk("rd_valid_after_init", {31'd0, rd_valid}, 32'd1);
        tick();
        for (int i = 0; i < 16; i++) begin
            lookup(i[3:0], 8'h00);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        ld_valid    = 1'b0;
        ld_addr     = 4'd0;
        ld_data     = 8'h00;
        swap_req    = 1'b0;
        swap_addr_a = 4'd0;
        swap_addr_b = 4'd0;
        rd_addr     = 4'd0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_swap_ready", {31'd0, swap_ready}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_swap_done", {31'd0, swap_done}, 32'd0);
        tick();
        rst = 1'b0;
        init_sweep();

        load(4'd3, 8'hA5);
        load(4'd9, 8'h5A);
        lookup(4'd9, 8'h5A);
        lookup(4'd3, 8'hA5);

        swap(4'd3, 4'd9);
        @(negedge clk);
        chk("swap_ready_done", {31'd0, swap_ready}, 32'd1);
        tick();
        lookup(4'd3, 8'h5A);
        lookup(4'd9, 8'hA5);

        // Load and swap together: load wins, swap follows and sees the loaded value
        ld_valid    = 1'b1;
        ld_addr     = 4'd5;
        ld_data     = 8'h33;
        swap_req    = 1'b1;
        swap_addr_a = 4'd5;
        swap_addr_b = 4'd3;
        @(negedge clk);
        chk("arb_swap_ready", {31'd0, swap_ready}, 32'd0);
        chk("arb_ld_ready", {31'd0, ld_ready}, 32'd1);
        tick();
        ld_valid = 1'b0;
        swap(4'd5, 4'd3);
        lookup(4'd5, 8'h5A);
        lookup(4'd3, 8'h33);

        swap(4'd3, 4'd3);
        lookup(4'd3, 8'h33);

        // Second swap issued in the first one's done cycle
        swap(4'd9, 4'd5);
        swap(4'd3, 4'd9);
        lookup(4'd3, 8'h5A);
        lookup(4'd5, 8'hA5);
        lookup(4'd9, 8'h33);

        // Reset while in WR_A: swap abandoned, no done pulse, memory cleared again
        swap_req    = 1'b1;
        swap_addr_a = 4'd5;
        swap_addr_b = 4'd9;
        tick();
        swap_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        init_sweep();

        repeat (3) tick();
        chk("done_q_drained", done_q.size(), 32'd0);
        chk("rd_q_drained", rd_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
